// File: rtl/ext_bus_responder.sv
// External-bus slave: serves CPU word reads/writes from an internal RAM through a
// four-phase handshake, with a programmable number of wait states before ready.
module ext_bus_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ExternalAddressBus,
  inout  logic [31:0] ExternalDataBus,
  input  logic [2:0]  ExternalDrive,
  output logic        ExternalExchangeReady,
  output logic        ExternalBusError,
  output logic        Busy
);

  localparam int unsigned CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LASTI = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] LAST_CNT = LASTI[CW-1:0];

  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READY
  } state_t;

  state_t state, stateNext;
  logic [CW-1:0]         waitCnt, waitCntNext;
  logic                  latWrite, latInRange;
  logic [ADDR_WIDTH-1:0] latIdx;
  logic [31:0]           latData;
  logic [31:0]           readData;
  logic                  busErr;
  logic [31:0]           mem [DEPTH];

  logic                  liveReq, liveWrite, liveInRange;
  logic [ADDR_WIDTH-1:0] liveIdx;
  logic                  capture, enterReady, leaveReady, memWe;
  logic                  selWrite, selInRange;
  logic [ADDR_WIDTH-1:0] selIdx;
  logic [31:0]           selData;
  logic                  unusedAddrBits;

  assign unusedAddrBits = ^ExternalAddressBus[1:0];

  assign liveReq     = (ExternalDrive == CMD_READ) || (ExternalDrive == CMD_WRITE);
  assign liveWrite   = (ExternalDrive == CMD_WRITE);
  assign liveInRange = (ExternalAddressBus[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign liveIdx     = ExternalAddressBus[ADDR_WIDTH+1:2];

  // With zero wait states READY is entered on the capture edge itself, so the
  // live request is used there instead of the (not yet loaded) latches.
  assign selWrite   = (state == ST_IDLE) ? liveWrite       : latWrite;
  assign selInRange = (state == ST_IDLE) ? liveInRange     : latInRange;
  assign selIdx     = (state == ST_IDLE) ? liveIdx         : latIdx;
  assign selData    = (state == ST_IDLE) ? ExternalDataBus : latData;

  assign capture = (state == ST_IDLE) && liveReq;
  assign memWe   = enterReady && selWrite && selInRange && !rst;

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    enterReady  = 1'b0;
    leaveReady  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (liveReq) begin
          if (WAIT_CYCLES == 0) begin
            stateNext  = ST_READY;
            enterReady = 1'b1;
          end else begin
            stateNext   = ST_WAIT;
            waitCntNext = '0;
          end
        end
      end
      ST_WAIT: begin
        if (ExternalDrive == CMD_IDLE) begin
          stateNext   = ST_IDLE;
          waitCntNext = '0;
        end else if (waitCnt == LAST_CNT) begin
          stateNext  = ST_READY;
          enterReady = 1'b1;
        end else begin
          waitCntNext = waitCnt + 1'b1;
        end
      end
      ST_READY: begin
        if (ExternalDrive == CMD_IDLE) begin
          stateNext  = ST_IDLE;
          leaveReady = 1'b1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      waitCnt    <= '0;
      latWrite   <= 1'b0;
      latInRange <= 1'b0;
      latIdx     <= '0;
      latData    <= '0;
      readData   <= '0;
      busErr     <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (capture) begin
        latWrite   <= liveWrite;
        latInRange <= liveInRange;
        latIdx     <= liveIdx;
        latData    <= ExternalDataBus;
      end
      if (enterReady) begin
        busErr <= !selInRange;
        if (!selWrite)
          readData <= selInRange ? mem[selIdx] : '0;
      end else if (leaveReady) begin
        busErr <= 1'b0;
      end
    end
  end

  // RAM contents survive reset; memWe is masked while rst is high.
  always_ff @(posedge clk) begin
    if (memWe)
      mem[selIdx] <= selData;
  end

  assign ExternalExchangeReady = (state == ST_READY);
  assign Busy                  = (state != ST_IDLE);
  assign ExternalBusError      = busErr;
  assign ExternalDataBus = ((state == ST_READY) && !latWrite && (ExternalDrive == CMD_READ))
                           ? readData : 'z;

endmodule

// File: tb/tb_ext_bus_responder.sv
// Directed bench for ext_bus_responder: one instance with default wait states,
// one with zero wait states; an undriven data bus reads back as all ones.
module tb_ext_bus_responder;

  localparam logic [31:0] PULL = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic [31:0] addrA, cpuDataA, addrB, cpuDataB;
  logic [2:0]  cmdA, cmdB;
  logic        cpuEnA, cpuEnB;
  logic        readyA, errA, busyA, readyB, errB, busyB;
  wire  [31:0] busA, busB;

  int total = 0;
  int bad   = 0;

  assign busA = cpuEnA ? cpuDataA : 'z;
  assign busB = cpuEnB ? cpuDataB : 'z;

  for (genvar g = 0; g < 32; g++) begin : gPull
    pullup (busA[g]);
    pullup (busB[g]);
  end

  ext_bus_responder dutA (
    .clk(clk), .rst(rst),
    .ExternalAddressBus(addrA), .ExternalDataBus(busA), .ExternalDrive(cmdA),
    .ExternalExchangeReady(readyA), .ExternalBusError(errA), .Busy(busyA)
  );

  ext_bus_responder #(.WAIT_CYCLES(0)) dutB (
    .clk(clk), .rst(rst),
    .ExternalAddressBus(addrB), .ExternalDataBus(busB), .ExternalDrive(cmdB),
    .ExternalExchangeReady(readyB), .ExternalBusError(errB), .Busy(busyB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $error("FAIL timeout: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wrA(input logic [31:0] addr, input logic [31:0] data, input logic expErr);
    addrA = addr; cmdA = 3'b010; cpuDataA = data; cpuEnA = 1'b1;
    tick(); chk("wrA.rdyAfterN", readyA, 0); chk("wrA.busy", busyA, 1);
    tick(); chk("wrA.rdyAfterN1", readyA, 0);
    tick(); chk("wrA.rdyAfterN2", readyA, 1); chk("wrA.err", errA, expErr);
    cmdA = 3'b000; cpuEnA = 1'b0;
    tick(); chk("wrA.rdyDrop", readyA, 0); chk("wrA.errDrop", errA, 0); chk("wrA.busyDrop", busyA, 0);
  endtask

  task automatic rdA(input logic [31:0] addr, input logic [31:0] expData, input logic expErr);
    addrA = addr; cmdA = 3'b001;
    tick(); chk("rdA.rdyAfterN", readyA, 0);
    tick(); chk("rdA.rdyAfterN1", readyA, 0); chk("rdA.busWait", busA, PULL);
    tick(); chk("rdA.rdyAfterN2", readyA, 1); chk("rdA.data", busA, expData); chk("rdA.err", errA, expErr);
    cmdA = 3'b000;
    #1 chk("rdA.busRelease", busA, PULL);
    tick(); chk("rdA.rdyDrop", readyA, 0);
  endtask

  task automatic wrB(input logic [31:0] addr, input logic [31:0] data);
    addrB = addr; cmdB = 3'b010; cpuDataB = data; cpuEnB = 1'b1;
    tick(); chk("wrB.rdyAfterN", readyB, 1); chk("wrB.err", errB, 0);
    cmdB = 3'b000; cpuEnB = 1'b0;
    tick(); chk("wrB.rdyDrop", readyB, 0);
  endtask

  task automatic rdB(input logic [31:0] addr, input logic [31:0] expData);
    addrB = addr; cmdB = 3'b001;
    tick(); chk("rdB.rdyAfterN", readyB, 1); chk("rdB.data", busB, expData); chk("rdB.err", errB, 0);
    cmdB = 3'b000;
    tick(); chk("rdB.rdyDrop", readyB, 0); chk("rdB.busRelease", busB, PULL);
  endtask

  initial begin
    rst = 1'b1;
    addrA = '0; cmdA = 3'b000; cpuDataA = '0; cpuEnA = 1'b0;
    addrB = '0; cmdB = 3'b000; cpuDataB = '0; cpuEnB = 1'b0;
    tick(); tick();
    chk("rst.ready", readyA, 0); chk("rst.err", errA, 0);
    chk("rst.busy", busyA, 0);   chk("rst.bus", busA, PULL);
    chk("rst.readyB", readyB, 0);
    rst = 1'b0;
    tick();

    // Reset during WAIT of a write: nothing committed
    wrA(32'h10, 32'h0000_0111, 1'b0);
    addrA = 32'h10; cmdA = 3'b010; cpuDataA = 32'h0000_0501; cpuEnA = 1'b1;
    tick(); chk("abortRst.busy", busyA, 1);
    tick();
    rst = 1'b1; cmdA = 3'b000; cpuEnA = 1'b0;
    #1 chk("abortRst.ready", readyA, 0); chk("abortRst.busy0", busyA, 0); chk("abortRst.bus", busA, PULL);
    tick(); chk("abortRst.readyHeld", readyA, 0);
    rst = 1'b0;
    tick();
    rdA(32'h10, 32'h0000_0111, 1'b0);

    // Write then read back to back
    wrA(32'h10, 32'h0000_0501, 1'b0);
    rdA(32'h10, 32'h0000_0501, 1'b0);

    // Out-of-range window
    wrA(32'h0, 32'h0000_ABCD, 1'b0);
    wrA(32'h400, 32'h0000_1234, 1'b1);
    rdA(32'h0, 32'h0000_ABCD, 1'b0);
    rdA(32'h400, 32'h0000_0000, 1'b1);

    // Abort during WAIT, read then write
    wrA(32'h20, 32'h0000_2222, 1'b0);
    addrA = 32'h20; cmdA = 3'b001;
    tick(); tick();
    cmdA = 3'b000;
    #1 chk("abortRd.bus", busA, PULL);
    tick(); chk("abortRd.ready", readyA, 0); chk("abortRd.busy", busyA, 0);
    tick(); chk("abortRd.readyLater", readyA, 0);
    addrA = 32'h20; cmdA = 3'b010; cpuDataA = 32'h0000_9999; cpuEnA = 1'b1;
    tick(); tick();
    cmdA = 3'b000; cpuEnA = 1'b0;
    tick(); chk("abortWr.ready", readyA, 0); chk("abortWr.busy", busyA, 0);
    tick();
    rdA(32'h20, 32'h0000_2222, 1'b0);

    // Hold READ for five cycles after ready, then turnaround
    addrA = 32'h10; cmdA = 3'b001;
    tick(); tick(); tick();
    chk("hold.ready0", readyA, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold.ready", readyA, 1);
      chk("hold.data", busA, 32'h0000_0501);
    end
    cmdA = 3'b000;
    #1 chk("turn.bus", busA, PULL); chk("turn.readyStill", readyA, 1);
    tick(); chk("turn.readyDrop", readyA, 0); chk("turn.busy", busyA, 0);

    // Reserved command is ignored
    cmdA = 3'b111;
    tick(); tick(); tick();
    chk("rsvd.ready", readyA, 0); chk("rsvd.busy", busyA, 0); chk("rsvd.bus", busA, PULL);
    cmdA = 3'b000;
    tick();

    // Zero-wait instance: last word, no wrap onto word 0
    wrB(32'h0, 32'h0000_0005);
    wrB(32'h3FC, 32'hCAFE_F00D);
    rdB(32'h3FC, 32'hCAFE_F00D);
    rdB(32'h0, 32'h0000_0005);
    cmdB = 3'b111;
    tick(); chk("rsvdB.ready", readyB, 0); chk("rsvdB.busy", busyB, 0);
    cmdB = 3'b000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ext_bus_responder.md
Name: ext_bus_responder

Overview:
- External-side slave that answers the CPU's external exchange requests: CPU presents ExternalAddressBus and ExternalDrive; block serves word reads/writes from an internal RAM, then raises ExternalExchangeReady.
- Four-phase handshake with programmable wait states.
- Used as the memory/peripheral model on the CPU's external bus in system benches, and as the synthesizable external RAM on the board build.

Parameters:
- ADDR_WIDTH, 8, word-index width; RAM holds 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, extra cycles between request capture and ready (0 allowed).
- BASE_ADDR, 32'h0000_0000, byte base of decoded window; must be aligned to 4*2^ADDR_WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- ExternalAddressBus  input  32  byte address, CPU-driven, held stable for whole transaction
- ExternalDataBus  inout  32  write data from CPU / read data from this block
- ExternalDrive  input  3  CPU command: 3'b000 IDLE, 3'b001 READ, 3'b010 WRITE, others reserved
- ExternalExchangeReady  output  1  transaction complete, held until CPU returns to IDLE
- ExternalBusError  output  1  address outside window; valid while ExternalExchangeReady=1
- Busy  output  1  high in WAIT or READY

Behaviour:
- Reset (async, active-high):
  - state IDLE, ExternalExchangeReady=0, ExternalBusError=0, Busy=0, ExternalDataBus=Z, wait counter 0.
  - RAM contents not cleared.
  - Reset mid-transaction abandons it; no write is committed.
- Address decode:
  - in_range = (addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]).
  - Word index = addr[ADDR_WIDTH+1:2].
  - addr[1:0] ignored (word access only).
- FSM IDLE / WAIT / READY:
  - IDLE:
    - On edge N with ExternalDrive = READ or WRITE: latch op, address, in_range, and write data from ExternalDataBus.
    - Go to READY if WAIT_CYCLES=0, else go to WAIT with counter=0.
    - Reserved codes are ignored and state stays IDLE.
  - WAIT:
    - Counter increments each edge; when counter==WAIT_CYCLES-1, go to READY.
    - Net effect: ExternalExchangeReady is high after edge N+WAIT_CYCLES.
    - If ExternalDrive==IDLE at any WAIT edge: abort to IDLE, no write, ready never asserted.
    - Changes of ExternalDrive to another non-IDLE code during WAIT are ignored; the latched op is used.
  - Entering READY:
    - WRITE with in_range: RAM[index] <= latched data (commit on that same edge).
    - READ: read register <= RAM[index] if in_range, else 32'h0000_0000.
    - ExternalBusError <= !in_range.
    - Out-of-range WRITE is discarded.
  - READY:
    - ExternalExchangeReady=1 and Busy=1, held while ExternalDrive != IDLE.
    - On the first edge where ExternalDrive==IDLE: go to IDLE; ready and error drop after that edge.
    - A new request can be captured no earlier than the following edge, so there is always at least one IDLE cycle between transactions.
- Data bus tristate:
  - Drive ExternalDataBus = read register only when state==READY, latched op==READ, and current ExternalDrive==READ.
  - Otherwise Z. This drops the bus combinationally the moment the CPU leaves READ, so bus turnaround has no contention.
  - The block never drives during WRITE.
- Back-to-back: a READ following a WRITE to the same address returns the newly written value.

Test Plan:
- Reset and idle: assert rst mid-WAIT of a WRITE to 0x10 with data 0x501, then read 0x10 → ready low during reset, ExternalDataBus=Z, and the read returns the old contents (not 0x501).
- Write/read, default params: WRITE 0x10 with data 0x0000_0501 captured at edge N → ready high after edge N+2; drop to IDLE; READ 0x10 → ExternalDataBus=0x0000_0501 with ready high after edge M+2, ExternalBusError=0.
- Zero wait: WAIT_CYCLES=0, READ 0x3FC after writing 0xCAFEF00D → ready high after capture edge N, data 0xCAFEF00D; last word index 255 reached with no wrap.
- Out of range: WRITE 0x400 with 0x1234 → ready high with ExternalBusError=1; RAM[0] unchanged. READ 0x400 → data 0x0, ExternalBusError=1.
- Abort: READ 0x20, ExternalDrive→IDLE after 1 WAIT cycle → ready never asserts, bus stays Z, state IDLE next edge. A WRITE aborted the same way leaves RAM unchanged.
- Hold and turnaround: CPU holds READ for 5 cycles after ready → ready and data stable for all 5. ExternalDrive→IDLE → bus Z in the same cycle, ready low after the next edge; a reserved code 3'b111 while IDLE → no response.
